ex_fwd_source: RTL and testbench

//  Back-end producer of the EX-stage forwarding interface. Holds the EX/MEM
//  and MEM/WB pipeline registers and drives ex_mem_alu_result,
//  mem_wb_write_back_result, and the 2-bit Forward_A/Forward_B selects the
//  EX stage consumes (00 = regfile, 01 = MEM/WB, 10 = EX/MEM, 11 never).

---
 rtl/ex_fwd_source.sv | 143 ++++++++++++++
 tb/tb_ex_fwd_source.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_fwd_source.sv
// ex_fwd_source: EX/MEM and MEM/WB pipeline registers plus the forwarding
// selects and load-use detection that the EX stage consumes. Also keeps a
// wrapping count of register-file writes that actually retire.
module ex_fwd_source #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     ex_alu_result,
  input  logic [DATA_W-1:0]     ex_alu_in2,
  input  logic [REG_ADDR_W-1:0] ex_dest_reg,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_to_reg,
  input  logic                  ex_mem_write,
  input  logic [DATA_W-1:0]     mem_read_data,
  input  logic [REG_ADDR_W-1:0] id_ex_rs,
  input  logic [REG_ADDR_W-1:0] id_ex_rt,
  input  logic                  stall,
  input  logic                  flush_ex,
  output logic [DATA_W-1:0]     ex_mem_alu_result,
  output logic [DATA_W-1:0]     ex_mem_store_data,
  output logic                  ex_mem_mem_write,
  output logic                  ex_mem_mem_read,
  output logic [DATA_W-1:0]     mem_wb_write_back_result,
  output logic [REG_ADDR_W-1:0] mem_wb_dest_reg,
  output logic                  mem_wb_reg_write,
  output logic [1:0]            Forward_A,
  output logic [1:0]            Forward_B,
  output logic                  load_use_hazard,
  output logic [CNT_W-1:0]      wb_count
);

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'b00,
    FWD_MEM_WB  = 2'b01,
    FWD_EX_MEM  = 2'b10
  } fwd_sel_e;

  // EX/MEM state not visible directly on the ports.
  logic [REG_ADDR_W-1:0] ex_mem_dest_reg;
  logic                  ex_mem_reg_write;
  logic                  ex_mem_mem_to_reg;

  // A producer can only feed a consumer if it writes a real register.
  logic ex_mem_writes_reg;
  logic mem_wb_writes_reg;

  assign ex_mem_writes_reg = ex_mem_reg_write && (ex_mem_dest_reg != '0);
  assign mem_wb_writes_reg = mem_wb_reg_write && (mem_wb_dest_reg != '0);
  assign ex_mem_mem_read   = ex_mem_mem_to_reg;

  // Newest value wins; a load still in EX/MEM has no data yet, so it is
  // never a forwarding source (load_use_hazard covers that case instead).
  function automatic logic [1:0] fwd_select(
    input logic [REG_ADDR_W-1:0] src,
    input logic                  exm_wr,
    input logic                  exm_load,
    input logic [REG_ADDR_W-1:0] exm_dest,
    input logic                  mwb_wr,
    input logic [REG_ADDR_W-1:0] mwb_dest
  );
    logic [1:0] sel;
    sel = FWD_REGFILE;
    if (exm_wr && !exm_load && (exm_dest == src))
      sel = FWD_EX_MEM;
    else if (mwb_wr && (mwb_dest == src))
      sel = FWD_MEM_WB;
    return sel;
  endfunction

  // EX/MEM register: stall holds, flush inserts an all-zero bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
      ex_mem_alu_result <= '0;
      ex_mem_store_data <= '0;
      ex_mem_dest_reg   <= '0;
      ex_mem_reg_write  <= 1'b0;
      ex_mem_mem_to_reg <= 1'b0;
      ex_mem_mem_write  <= 1'b0;
    end else if (stall) begin
      ex_mem_alu_result <= ex_mem_alu_result;
    end else if (flush_ex) begin
      ex_mem_alu_result <= '0;
      ex_mem_store_data <= '0;
      ex_mem_dest_reg   <= '0;
      ex_mem_reg_write  <= 1'b0;
      ex_mem_mem_to_reg <= 1'b0;
      ex_mem_mem_write  <= 1'b0;
    end else begin
      ex_mem_alu_result <= ex_alu_result;
      ex_mem_store_data <= ex_alu_in2;
      ex_mem_dest_reg   <= ex_dest_reg;
      ex_mem_reg_write  <= ex_reg_write;
      ex_mem_mem_to_reg <= ex_mem_to_reg;
      ex_mem_mem_write  <= ex_mem_write;
    end
  end

  // MEM/WB register: selects load data or ALU result for writeback.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_wb_write_back_result <= '0;
      mem_wb_dest_reg          <= '0;
      mem_wb_reg_write         <= 1'b0;
    end else if (!stall) begin
      mem_wb_write_back_result <= ex_mem_mem_to_reg ? mem_read_data
                                                    : ex_mem_alu_result;
      mem_wb_dest_reg          <= ex_mem_dest_reg;
      mem_wb_reg_write         <= ex_mem_reg_write;
    end
  end

  // Retired-writeback counter: counts the write leaving MEM/WB this edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      wb_count <= '0;
    else if (!stall && mem_wb_writes_reg)
      wb_count <= wb_count + CNT_W'(1);
  end

  // Forwarding selects and load-use detection from registered state.
  always_comb begin
    // NOTE: every output of this block is assigned a default first, so no
    // path through it can leave a value unassigned and infer a latch.
    Forward_A       = FWD_REGFILE;
    Forward_B       = FWD_REGFILE;
    load_use_hazard = 1'b0;

    Forward_A = fwd_select(id_ex_rs, ex_mem_writes_reg, ex_mem_mem_to_reg,
                           ex_mem_dest_reg, mem_wb_writes_reg, mem_wb_dest_reg);
    Forward_B = fwd_select(id_ex_rt, ex_mem_writes_reg, ex_mem_mem_to_reg,
                           ex_mem_dest_reg, mem_wb_writes_reg, mem_wb_dest_reg);

    if (ex_mem_writes_reg && ex_mem_mem_to_reg &&
        ((ex_mem_dest_reg == id_ex_rs) || (ex_mem_dest_reg == id_ex_rt)))
      load_use_hazard = 1'b1;
  end

endmodule

// File: tb/tb_ex_fwd_source.sv
// Directed bench for ex_fwd_source. The stimulus process pushes a full
// expected output snapshot for the current cycle; a monitor pops it on the
// falling edge and compares it against the outputs.
module tb_ex_fwd_source;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 4;   // small so the wrap is reachable quickly

  logic                  clk;
  logic                  reset;
  logic [DATA_W-1:0]     ex_alu_result;
  logic [DATA_W-1:0]     ex_alu_in2;
  logic [REG_ADDR_W-1:0] ex_dest_reg;
  logic                  ex_reg_write;
  logic                  ex_mem_to_reg;
  logic                  ex_mem_write;
  logic [DATA_W-1:0]     mem_read_data;
  logic [REG_ADDR_W-1:0] id_ex_rs;
  logic [REG_ADDR_W-1:0] id_ex_rt;
  logic                  stall;
  logic                  flush_ex;
  logic [DATA_W-1:0]     ex_mem_alu_result;
  logic [DATA_W-1:0]     ex_mem_store_data;
  logic                  ex_mem_mem_write;
  logic                  ex_mem_mem_read;
  logic [DATA_W-1:0]     mem_wb_write_back_result;
  logic [REG_ADDR_W-1:0] mem_wb_dest_reg;
  logic                  mem_wb_reg_write;
  logic [1:0]            Forward_A;
  logic [1:0]            Forward_B;
  logic                  load_use_hazard;
  logic [CNT_W-1:0]      wb_count;

  ex_fwd_source #(
    .DATA_W    (DATA_W),
    .REG_ADDR_W(REG_ADDR_W),
    .CNT_W     (CNT_W)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .ex_alu_result           (ex_alu_result),
    .ex_alu_in2              (ex_alu_in2),
    .ex_dest_reg             (ex_dest_reg),
    .ex_reg_write            (ex_reg_write),
    .ex_mem_to_reg           (ex_mem_to_reg),
    .ex_mem_write            (ex_mem_write),
    .mem_read_data           (mem_read_data),
    .id_ex_rs                (id_ex_rs),
    .id_ex_rt                (id_ex_rt),
    .stall                   (stall),
    .flush_ex                (flush_ex),
    .ex_mem_alu_result       (ex_mem_alu_result),
    .ex_mem_store_data       (ex_mem_store_data),
    .ex_mem_mem_write        (ex_mem_mem_write),
    .ex_mem_mem_read         (ex_mem_mem_read),
    .mem_wb_write_back_result(mem_wb_write_back_result),
    .mem_wb_dest_reg         (mem_wb_dest_reg),
    .mem_wb_reg_write        (mem_wb_reg_write),
    .Forward_A               (Forward_A),
    .Forward_B               (Forward_B),
    .load_use_hazard         (load_use_hazard),
    .wb_count                (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [31:0]      alu;
    logic [31:0]      st;
    logic             mw;
    logic             mr;
    logic [31:0]      wbr;
    logic [4:0]       wbd;
    logic             wbw;
    logic [1:0]       fa;
    logic [1:0]       fb;
    logic             hz;
    logic [CNT_W-1:0] cnt;
  } snap_t;

  snap_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic check(input string nm, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, field, act, exp);
    end
  endtask

  // Monitor: compare the pending snapshot once outputs have settled.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      snap_t e;
      e = exp_q.pop_front();
      check(e.name, "ex_mem_alu_result", ex_mem_alu_result, e.alu);
      check(e.name, "ex_mem_store_data", ex_mem_store_data, e.st);
      check(e.name, "ex_mem_mem_write", 32'(ex_mem_mem_write), 32'(e.mw));
      check(e.name, "ex_mem_mem_read", 32'(ex_mem_mem_read), 32'(e.mr));
      check(e.name, "wb_result", mem_wb_write_back_result, e.wbr);
      check(e.name, "wb_dest", 32'(mem_wb_dest_reg), 32'(e.wbd));
      check(e.name, "wb_reg_write", 32'(mem_wb_reg_write), 32'(e.wbw));
      check(e.name, "Forward_A", 32'(Forward_A), 32'(e.fa));
      check(e.name, "Forward_B", 32'(Forward_B), 32'(e.fb));
      check(e.name, "load_use_hazard", 32'(load_use_hazard), 32'(e.hz));
      check(e.name, "wb_count", 32'(wb_count), 32'(e.cnt));
    end
  end

  task automatic expect_snap(input string nm,
                             input logic [31:0] alu, input logic [31:0] st,
                             input logic mw, input logic mr,
                             input logic [31:0] wbr, input logic [4:0] wbd,
                             input logic wbw, input logic [1:0] fa,
                             input logic [1:0] fb, input logic hz,
                             input logic [CNT_W-1:0] cnt);
    snap_t s;
    s.name = nm; s.alu = alu; s.st = st; s.mw = mw; s.mr = mr;
    s.wbr = wbr; s.wbd = wbd; s.wbw = wbw; s.fa = fa; s.fb = fb;
    s.hz = hz; s.cnt = cnt;
    exp_q.push_back(s);
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] in2,
                       input logic [4:0] dest, input logic rw,
                       input logic m2r, input logic mw,
                       input logic [4:0] rs, input logic [4:0] rt);
    ex_alu_result = alu;
    ex_alu_in2    = in2;
    ex_dest_reg   = dest;
    ex_reg_write  = rw;
    ex_mem_to_reg = m2r;
    ex_mem_write  = mw;
    id_ex_rs      = rs;
    id_ex_rt      = rt;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b0;
    stall         = 1'b0;
    flush_ex      = 1'b0;
    mem_read_data = '0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    step();
    expect_snap("reset", 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);

    // Back-to-back dependency on r3
    step(); reset = 1'b1;
    drive(32'h10, 32'h55, 3, 1, 0, 0, 0, 0);
    step(); drive(32'h20, 32'h66, 4, 1, 0, 0, 3, 0);
    expect_snap("dep_exmem", 32'h10, 32'h55, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0);
    step(); drive(32'hBB, 0, 5, 1, 0, 0, 3, 4);
    expect_snap("dep_memwb", 32'h20, 32'h66, 0, 0, 32'h10, 3, 1, 2'b01, 2'b10, 0, 0);

    // Both stages writing r5, newest wins; then r0 writes
    step(); drive(32'hAA, 0, 5, 1, 0, 0, 4, 5);
    expect_snap("mixed", 32'hBB, 0, 0, 0, 32'h20, 4, 1, 2'b01, 2'b10, 0, 1);
    step(); drive(32'h77, 0, 0, 1, 0, 0, 5, 5);
    expect_snap("newest_wins", 32'hAA, 0, 0, 0, 32'hBB, 5, 1, 2'b10, 2'b10, 0, 2);
    step(); drive(32'h88, 0, 0, 1, 0, 0, 0, 0);
    expect_snap("r0_exmem", 32'h77, 0, 0, 0, 32'hAA, 5, 1, 2'b00, 2'b00, 0, 3);

    // Load to r7 followed by a consumer of r7
    step(); drive(32'h100, 0, 7, 1, 1, 0, 0, 0);
    expect_snap("r0_both", 32'h88, 0, 0, 0, 32'h77, 0, 1, 2'b00, 2'b00, 0, 4);
    step(); drive(32'h300, 0, 8, 0, 0, 0, 1, 7);
    mem_read_data = 32'hDEAD;
    expect_snap("load_use", 32'h100, 0, 0, 1, 32'h88, 0, 1, 2'b00, 2'b00, 1, 4);
    step(); drive(32'h400, 32'h1234, 9, 0, 0, 1, 7, 7);
    expect_snap("load_fwd", 32'h300, 0, 0, 0, 32'hDEAD, 7, 1, 2'b01, 2'b01, 0, 4);

    // Three stalled edges with changing EX inputs, then a flush
    step(); stall = 1'b1; drive(32'h500, 0, 10, 1, 0, 0, 0, 0);
    expect_snap("pre_stall", 32'h400, 32'h1234, 1, 0, 32'h300, 8, 0, 2'b00, 2'b00, 0, 5);
    step(); drive(32'h600, 0, 10, 1, 0, 0, 0, 0);
    expect_snap("stall1", 32'h400, 32'h1234, 1, 0, 32'h300, 8, 0, 2'b00, 2'b00, 0, 5);
    step(); drive(32'h700, 0, 10, 1, 0, 0, 0, 0);
    expect_snap("stall2", 32'h400, 32'h1234, 1, 0, 32'h300, 8, 0, 2'b00, 2'b00, 0, 5);
    step(); stall = 1'b0; flush_ex = 1'b1; drive(32'h800, 0, 12, 1, 0, 1, 0, 0);
    expect_snap("stall3", 32'h400, 32'h1234, 1, 0, 32'h300, 8, 0, 2'b00, 2'b00, 0, 5);
    step(); flush_ex = 1'b0; drive(32'h900, 0, 11, 1, 0, 0, 0, 0);
    expect_snap("flush", 0, 0, 0, 0, 32'h400, 9, 0, 2'b00, 2'b00, 0, 5);

    // Asynchronous reset between edges while r11 sits in EX/MEM
    step(); reset = 1'b0; drive(32'h900, 0, 11, 1, 0, 0, 11, 0);
    expect_snap("async_reset", 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);

    // Counter wrap: 16 retired writes to r1 on a 4-bit counter
    for (int i = 0; i < 16; i++) begin
      step();
      if (i == 0) reset = 1'b1;
      drive(32'h42, 0, 1, 1, 0, 0, 0, 0);
      if (i == 9)
        expect_snap("count7", 32'h42, 0, 0, 0, 32'h42, 1, 1, 2'b00, 2'b00, 0, 7);
    end
    step(); drive(0, 0, 0, 0, 0, 0, 0, 0);
    step(); drive(0, 0, 0, 0, 0, 0, 1, 0);
    expect_snap("count_max", 0, 0, 0, 0, 32'h42, 1, 1, 2'b01, 2'b00, 0, 15);
    step();
    expect_snap("count_wrap", 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d snapshots left unchecked, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
